wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH_PRD, default 7, physical register tag width.
REQ-002 SHALL have parameter MAX_WAIT, default 4, cycles a buffered MulDiv result may lose arbitration before ALU hold asserts (range 1..15).
REQ-003 i_clk  input  1  clock, all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_alu_valid  input  1  ALU1 result present this cycle (fixed latency, cannot stall).
REQ-006 i_alu_prd  input  WIDTH_PRD  ALU1 destination physical register.
REQ-007 i_alu_data  input  32  ALU1 result.
REQ-008 i_md_valid  input  1  MulDiv result offered.
REQ-009 i_md_prd  input  WIDTH_PRD  MulDiv destination physical register.
REQ-010 i_md_data  input  32  MulDiv result.
REQ-011 o_md_ready  output  1  MulDiv result accepted when i_md_valid & o_md_ready.
REQ-012 o_we  output  1  regfile write port 1 enable, registered.
REQ-013 o_waddr  output  WIDTH_PRD  write address, registered; also busy-table/issue-queue wakeup tag.
REQ-014 o_wdata  output  32  write data, registered.
REQ-015 o_alu_hold  output  1  request to ALU1 issue slot: issue no new ALU op while high.

Function
REQ-016 SHALL contain a 2-entry FIFO (head, tail, count 0..2) holding {prd, data} MulDiv results.
REQ-017 o_md_ready SHALL equal (count < 2), combinational from state only.
REQ-018 Each cycle, winner selection: i_alu_valid -> ALU; else FIFO non-empty -> FIFO head (popped); else none.
REQ-019 Write outputs SHALL update one edge after selection: o_we=1 with winner's prd/data; o_we=0 with o_waddr/o_wdata holding previous values when none wins.
REQ-020 ALU result SHALL never be delayed or dropped; ALU-to-o_we latency is exactly 1 cycle.
REQ-021 Accepted MulDiv result SHALL be pushed at the edge; push and pop in the same cycle at count=2 is impossible (ready low); at count=1 push+pop leaves count=1.
REQ-022 MulDiv results SHALL be written in acceptance order.
REQ-023 Starvation counter wait_cnt (4 bits): increments when FIFO non-empty and ALU wins; clears when FIFO head pops or FIFO empty; saturates at MAX_WAIT.
REQ-024 Two-state FSM: NORMAL -> STARVE when wait_cnt reaches MAX_WAIT; STARVE -> NORMAL at the edge the FIFO head pops.
REQ-025 o_alu_hold SHALL be 1 exactly in STARVE (registered state); in-flight ALU ops still win until the slot empties.
REQ-026 Reset mid-operation SHALL discard FIFO contents and any pending write.

Reset
REQ-027 On i_rst_n=0: count=0, pointers=0, wait_cnt=0, state NORMAL, o_we=0, o_waddr=0, o_wdata=0, o_alu_hold=0, o_md_ready=1.
REQ-028 Reset SHALL be asynchronous assertion; state held while low.

Configuration
REQ-029 Macro WB_MD_BYPASS_EN defined: when FIFO empty, i_alu_valid=0 and MulDiv handshake occurs, result SHALL cut through to o_we next edge without entering FIFO (MulDiv latency 1).
REQ-030 Macro WB_MD_BYPASS_EN undefined: every MulDiv result SHALL enter FIFO first (minimum MulDiv latency 2 cycles).

Verification
REQ-031 Reset with i_rst_n=0 mid-stream -> all outputs zero, o_md_ready=1, count=0 immediately (asynchronous).
REQ-032 ALU only, prd=0x12 data=0xDEADBEEF -> next cycle o_we=1, o_waddr=0x12, o_wdata=0xDEADBEEF.
REQ-033 MulDiv prd=0x05 data=0x1234 with ALU idle -> o_we at +1 cycle with bypass macro, +2 without.
REQ-034 ALU valid every cycle, two MulDiv results pushed -> o_md_ready=0 after second push; third offer not accepted; FIFO order preserved.
REQ-035 ALU valid continuously, one MulDiv buffered, MAX_WAIT=4 -> o_alu_hold=1 after 4 lost cycles; on first ALU-idle cycle head written, o_alu_hold=0 next cycle.
REQ-036 Simultaneous ALU prd=0x01 and MulDiv prd=0x02, FIFO empty -> ALU written at +1, MulDiv at +2 (first ALU-idle cycle).

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU1 always wins regfile port 1; MulDiv results queue in a 2-deep FIFO.
// Optional macro WB_MD_BYPASS_EN lets a MulDiv result cut through when the FIFO is empty and ALU1 is idle.
module wb_arbiter #(
  parameter int WIDTH_PRD = 7,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alu_valid,
  input  logic [WIDTH_PRD-1:0] i_alu_prd,
  input  logic [31:0]          i_alu_data,
  input  logic                 i_md_valid,
  input  logic [WIDTH_PRD-1:0] i_md_prd,
  input  logic [31:0]          i_md_data,
  output logic                 o_md_ready,
  output logic                 o_we,
  output logic [WIDTH_PRD-1:0] o_waddr,
  output logic [31:0]          o_wdata,
  output logic                 o_alu_hold
);

  typedef enum logic {NORMAL = 1'b0, STARVE = 1'b1} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [WIDTH_PRD-1:0] fifo_prd  [2];
  logic [31:0]          fifo_data [2];
  logic                 head;
  logic                 tail;
  logic [1:0]           count;
  logic [3:0]           wait_cnt;
  logic [3:0]           wait_cnt_next;
  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 pop;
  logic                 push;
  logic                 bypass;

  assign o_md_ready = (count < 2'd2);
  assign o_alu_hold = (state == STARVE);

  always_comb begin
    accept = i_md_valid & o_md_ready;
    pop    = ~i_alu_valid & (count != 2'd0);
`ifdef WB_MD_BYPASS_EN
    bypass = accept & ~i_alu_valid & (count == 2'd0);
`else
    bypass = 1'b0;
`endif
    push   = accept & ~bypass;
  end

  // Starvation counter tracks how long the current FIFO head has lost to ALU1.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (pop || (count == 2'd0)) begin
      wait_cnt_next = 4'd0;
    end else if (i_alu_valid && (wait_cnt < MAX_WAIT_C)) begin
      wait_cnt_next = wait_cnt + 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      NORMAL: if (wait_cnt_next == MAX_WAIT_C) state_next = STARVE;
      STARVE: if (pop) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head     <= 1'b0;
      tail     <= 1'b0;
      count    <= 2'd0;
      wait_cnt <= 4'd0;
      state    <= NORMAL;
    end else begin
      head     <= head ^ pop;
      tail     <= tail ^ push;
      count    <= count + {1'b0, push} - {1'b0, pop};
      wait_cnt <= wait_cnt_next;
      state    <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_prd[tail]  <= i_md_prd;
      fifo_data[tail] <= i_md_data;
    end
  end

  // Address/data hold their last value when nothing wins so the wakeup tag stays stable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else if (i_alu_valid) begin
      o_we    <= 1'b1;
      o_waddr <= i_alu_prd;
      o_wdata <= i_alu_data;
    end else if (pop) begin
      o_we    <= 1'b1;
      o_waddr <= fifo_prd[head];
      o_wdata <= fifo_data[head];
    end else if (bypass) begin
      o_we    <= 1'b1;
      o_waddr <= i_md_prd;
      o_wdata <= i_md_data;
    end else begin
      o_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, latency/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  localparam int WIDTH_PRD = 7;
  localparam int MAX_WAIT  = 4;
`ifdef WB_MD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 alu_valid;
  logic [WIDTH_PRD-1:0] alu_prd;
  logic [31:0]          alu_data;
  logic                 md_valid;
  logic [WIDTH_PRD-1:0] md_prd;
  logic [31:0]          md_data;
  logic                 md_ready;
  logic                 we;
  logic [WIDTH_PRD-1:0] waddr;
  logic [31:0]          wdata;
  logic                 alu_hold;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.WIDTH_PRD(WIDTH_PRD), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(alu_valid), .i_alu_prd(alu_prd), .i_alu_data(alu_data),
    .i_md_valid(md_valid), .i_md_prd(md_prd), .i_md_data(md_data),
    .o_md_ready(md_ready), .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
    .o_alu_hold(alu_hold)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [6:0] ap, input logic [31:0] ad,
                       input logic mv, input logic [6:0] mp, input logic [31:0] md);
    alu_valid = av; alu_prd = ap; alu_data = ad;
    md_valid  = mv; md_prd  = mp; md_data  = md;
  endtask

  // Reference model: a queue of pending MulDiv results plus the head's lost-cycle count.
  typedef struct packed {
    logic [6:0]  prd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [6:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_lost;

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_lost = 0;
  endtask

  task automatic model_cycle(input string tag);
    bit   acc, took, was_empty;
    ent_t e;
    check({tag, "_ready"}, 32'(md_ready), 32'(q.size() < 2));
    acc       = md_valid && (q.size() < 2);
    took      = 1'b0;
    was_empty = (q.size() == 0);
    if (alu_valid) begin
      m_we = 1'b1; m_waddr = alu_prd; m_wdata = alu_data;
      if (!was_empty) m_lost++;
    end else if (!was_empty) begin
      e = q.pop_front();
      m_we = 1'b1; m_waddr = e.prd; m_wdata = e.data;
      m_lost = 0;
    end else if (BYPASS && acc) begin
      m_we = 1'b1; m_waddr = md_prd; m_wdata = md_data;
      took = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (acc && !took) q.push_back('{prd: md_prd, data: md_data});
    @(posedge clk);
    #1;
    check({tag, "_we"},    32'(we),       32'(m_we));
    check({tag, "_waddr"}, 32'(waddr),    32'(m_waddr));
    check({tag, "_wdata"}, wdata,         m_wdata);
    check({tag, "_hold"},  32'(alu_hold), 32'(m_lost >= MAX_WAIT));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},    32'(we),       32'd0);
    check({tag, "_waddr"}, 32'(waddr),    32'd0);
    check({tag, "_wdata"}, wdata,         32'd0);
    check({tag, "_hold"},  32'(alu_hold), 32'd0);
    check({tag, "_ready"}, 32'(md_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        av;
    logic [6:0]  ap;
    logic [31:0] ad;
    logic        mv;
    logic [6:0]  mp;
    logic [31:0] md;
    logic        rdy;
    logic        we;
    logic [6:0]  waddr;
    logic [31:0] wdata;
    logic        hold;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // av ap ad | mv mp md | rdy(before edge) | we waddr wdata hold (after edge)
    vecs[0]  = '{1, 7'h12, 32'hDEADBEEF, 0, 7'h00, 32'h0,  1, 1, 7'h12, 32'hDEADBEEF, 0};
    vecs[1]  = '{1, 7'h01, 32'h11111111, 1, 7'h02, 32'h22222222, 1, 1, 7'h01, 32'h11111111, 0};
    vecs[2]  = '{0, 7'h00, 32'h0,        0, 7'h00, 32'h0,  1, 1, 7'h02, 32'h22222222, 0};
    vecs[3]  = '{0, 7'h00, 32'h0,        0, 7'h00, 32'h0,  1, 0, 7'h02, 32'h22222222, 0};
    vecs[4]  = '{1, 7'h20, 32'hA0,       1, 7'h30, 32'hB0, 1, 1, 7'h20, 32'hA0, 0};
    vecs[5]  = '{1, 7'h21, 32'hA1,       1, 7'h31, 32'hB1, 1, 1, 7'h21, 32'hA1, 0};
    vecs[6]  = '{1, 7'h22, 32'hA2,       1, 7'h32, 32'hB2, 0, 1, 7'h22, 32'hA2, 0};
    vecs[7]  = '{1, 7'h23, 32'hA3,       1, 7'h32, 32'hB2, 0, 1, 7'h23, 32'hA3, 0};
    vecs[8]  = '{1, 7'h24, 32'hA4,       1, 7'h32, 32'hB2, 0, 1, 7'h24, 32'hA4, 1};
    vecs[9]  = '{1, 7'h25, 32'hA5,       1, 7'h32, 32'hB2, 0, 1, 7'h25, 32'hA5, 1};
    vecs[10] = '{0, 7'h00, 32'h0,        1, 7'h32, 32'hB2, 0, 1, 7'h30, 32'hB0, 0};
    vecs[11] = '{0, 7'h00, 32'h0,        1, 7'h32, 32'hB2, 1, 1, 7'h31, 32'hB1, 0};
    vecs[12] = '{0, 7'h00, 32'h0,        0, 7'h00, 32'h0,  1, 1, 7'h32, 32'hB2, 0};
    vecs[13] = '{0, 7'h00, 32'h0,        0, 7'h00, 32'h0,  1, 0, 7'h32, 32'hB2, 0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ap, vecs[i].ad, vecs[i].mv, vecs[i].mp, vecs[i].md);
      check($sformatf("vec%0d_ready", i), 32'(md_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_we", i),    32'(we),       32'(vecs[i].we));
      check($sformatf("vec%0d_waddr", i), 32'(waddr),    32'(vecs[i].waddr));
      check($sformatf("vec%0d_wdata", i), wdata,         vecs[i].wdata);
      check($sformatf("vec%0d_hold", i),  32'(alu_hold), 32'(vecs[i].hold));
    end

    // MulDiv latency with ALU idle and FIFO empty.
    do_reset();
    drive(0, 0, 0, 1, 7'h05, 32'h1234);
    @(posedge clk);
    #1;
    check("mdlat_we1", 32'(we), 32'(BYPASS));
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("mdlat_we2",    32'(we),    32'(!BYPASS));
    check("mdlat_waddr2", 32'(waddr), 32'h05);
    check("mdlat_wdata2", wdata,      32'h1234);

    // Randomized traffic with varying ALU pressure and mid-stream async resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int pct;
      pct = ((i / 200) % 3 == 0) ? 95 : (((i / 200) % 3 == 1) ? 50 : 10);
      @(negedge clk);
      drive($urandom_range(99) < pct, 7'($urandom), $urandom,
            1'($urandom_range(1)), 7'($urandom), $urandom);
      if (i == 777 || i == 1555 || i == 2333) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_zero($sformatf("async_rst%0d", i));
        @(posedge clk);
        #1;
        check_zero($sformatf("held_rst%0d", i));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
      end else begin
        model_cycle($sformatf("rnd%0d", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
